// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. The multiply uses
//               shift-add on operand magnitudes into a 64-bit product. The
//               divide uses restoring division. Sign correction is applied in
//               one FIXUP cycle after the iterations. When EARLY_OUT is set,
//               divide-by-zero and signed-overflow requests skip the iterations.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready  - request handshake, with op/op1/op2
//               out_valid/out_ready- result handshake, with result
//               busy               - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter logic EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_DIV    = 3'd4;
    localparam logic [2:0] c_OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;        // |op1|, the multiplicand
    logic [31:0] r_b;        // |op2|, the divisor
    logic [63:0] r_prod;     // high half accumulates; low half shifts out the multiplier
    logic [31:0] r_quot;     // shifts out the dividend and shifts in quotient bits
    logic [31:0] r_rem;
    logic        r_neg_p;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_result;

    // ---------------- request decode ----------------
    logic        w_accept;
    logic        w_s1;
    logic        w_s2;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic        w_ovf;
    logic        w_early;
    logic [31:0] w_early_result;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_s1       = op1[31] && ((op == c_OP_MUL) || (op == c_OP_MULH) || (op == c_OP_MULHSU)
                                    || (op == c_OP_DIV) || (op == c_OP_REM));
    assign w_s2       = op2[31] && ((op == c_OP_MUL) || (op == c_OP_MULH)
                                    || (op == c_OP_DIV) || (op == c_OP_REM));
    assign w_a_mag    = w_s1 ? (32'd0 - op1) : op1;
    assign w_b_mag    = w_s2 ? (32'd0 - op2) : op2;
    assign w_div_zero = (op2 == 32'd0);
    assign w_ovf      = ((op == c_OP_DIV) || (op == c_OP_REM))
                        && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    assign w_early    = EARLY_OUT && op[2] && (w_div_zero || w_ovf);

    // op[1] separates the remainder ops (6, 7) from the quotient ops (4, 5).
    always_comb begin
        w_early_result = 32'd0;
        if (w_div_zero) begin
            w_early_result = op[1] ? op1 : 32'hFFFF_FFFF;
        end else begin
            w_early_result = op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // ---------------- iteration datapath ----------------
    logic [32:0] w_mul_sum;
    logic [32:0] w_partial;
    logic [32:0] w_div_diff;

    assign w_mul_sum  = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_a} : 33'd0);
    assign w_partial  = {r_rem, r_quot[31]};
    assign w_div_diff = w_partial - {1'b0, r_b};

    // ---------------- sign fixup and result select ----------------
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_fix_result;

    assign w_prod_fix = r_neg_p ? (64'd0 - r_prod) : r_prod;
    assign w_quot_fix = r_neg_q ? (32'd0 - r_quot) : r_quot;
    assign w_rem_fix  = r_neg_r ? (32'd0 - r_rem)  : r_rem;

    always_comb begin
        w_fix_result = 32'd0;
        case (r_op)
            3'd0:          w_fix_result = w_prod_fix[31:0];
            3'd1, 3'd2,
            3'd3:          w_fix_result = w_prod_fix[63:32];
            3'd4, 3'd5:    w_fix_result = w_quot_fix;
            default:       w_fix_result = w_rem_fix;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = w_early ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == 5'd31) w_state_next = S_FIXUP;
            S_FIXUP: w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= 5'd0;
            r_op     <= 3'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_prod   <= 64'd0;
            r_quot   <= 32'd0;
            r_rem    <= 32'd0;
            r_neg_p  <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= 5'd0;
                        r_op    <= op;
                        r_a     <= w_a_mag;
                        r_b     <= w_b_mag;
                        r_prod  <= {32'd0, w_b_mag};
                        r_quot  <= w_a_mag;
                        r_rem   <= 32'd0;
                        r_neg_p <= w_s1 ^ w_s2;
                        // Iterating a zero divisor yields an all-ones quotient
                        // magnitude, which is already the required answer.
                        r_neg_q <= (w_s1 ^ w_s2) && !w_div_zero;
                        r_neg_r <= w_s1;
                        if (w_early) begin
                            r_result <= w_early_result;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_op[2]) begin
                        // Restoring step: bit 32 of the difference is the borrow.
                        if (!w_div_diff[32]) begin
                            r_rem  <= w_div_diff[31:0];
                            r_quot <= {r_quot[30:0], 1'b1};
                        end else begin
                            r_rem  <= w_partial[31:0];
                            r_quot <= {r_quot[30:0], 1'b0};
                        end
                    end else begin
                        r_prod <= {w_mul_sum, r_prod[31:1]};
                    end
                end
                S_FIXUP: begin
                    r_result <= w_fix_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Instance 0 has EARLY_OUT=0
//               and instance 1 has EARLY_OUT=1. Both instances are compared
//               against an arithmetic RV32M reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        in_valid;
    logic [1:0]        out_ready;
    logic [1:0][2:0]   op;
    logic [1:0][31:0]  op1;
    logic [1:0][31:0]  op2;
    wire  [1:0]        in_ready;
    wire  [1:0]        out_valid;
    wire  [1:0]        busy;
    wire  [1:0][31:0]  result;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.EARLY_OUT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op[0]), .op1(op1[0]), .op2(op2[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .result(result[0]), .busy(busy[0])
    );

    muldiv_unit #(.EARLY_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op[1]), .op1(op1[1]), .op2(op2[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .result(result[1]), .busy(busy[1])
    );

    // RV32M semantics computed with wide native arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pv;
        int          qa, qb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        qa = a;
        qb = b;
        case (o)
            3'd0: begin p = sa * sb; pv = p; return pv[31:0]; end
            3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
            3'd2: begin p = sa * ub; pv = p; return pv[63:32]; end
            3'd3: begin pv = {32'h0, a} * {32'h0, b}; return pv[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return qa / qb;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return qa % qb;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_early(input int d, input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
        bit ovf;
        ovf = (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        return (d == 1) && (o >= 3'd4) && (b == 32'd0 || ovf);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance d. It checks acceptance, latency
    // and result, holds out_ready low for `stall` extra cycles, and then
    // completes the handshake.
    task automatic do_op(input int d, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int stall);
        int lat;
        int exp_lat;
        exp_lat = is_early(d, o, a, b) ? 0 : 33;
        @(negedge clk);
        check("in_ready_before", {31'd0, in_ready[d]}, 32'd1);
        in_valid[d] = 1'b1;
        op[d]  = o;
        op1[d] = a;
        op2[d] = b;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        op[d]  = 3'($urandom);
        op1[d] = $urandom;
        op2[d] = $urandom;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency d%0d op%0d", d, o), lat, exp_lat);
        check($sformatf("result d%0d op%0d %h,%h", d, o, a, b), result[d], exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'd0, out_valid[d]}, 32'd1);
            check("stall_result", result[d], exp);
            check("stall_in_ready", {31'd0, in_ready[d]}, 32'd0);
        end
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        check("post_hs_valid", {31'd0, out_valid[d]}, 32'd0);
        check("post_hs_in_ready", {31'd0, in_ready[d]}, 32'd1);
        check("post_hs_busy", {31'd0, busy[d]}, 32'd0);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        int          d;
        int          sel;
        bit          saw_valid;

        rst_n     = 1'b0;
        in_valid  = 2'b00;
        out_ready = 2'b00;
        op        = '0;
        op1       = '0;
        op2       = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_in_ready", {31'd0, in_ready[k]}, 32'd1);
            check("rst_out_valid", {31'd0, out_valid[k]}, 32'd0);
            check("rst_busy", {31'd0, busy[k]}, 32'd0);
            check("rst_result", result[k], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed multiply and divide cases
        do_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        do_op(1, 3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        do_op(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        do_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        do_op(1, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        do_op(1, 3'd5, 32'd100, 32'd7, 32'd14, 0);
        do_op(1, 3'd7, 32'd100, 32'd7, 32'd2, 0);

        // Divide by zero and signed overflow, with and without early-out
        for (int k = 0; k < 2; k++) begin
            do_op(k, 3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0);
            do_op(k, 3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0);
            do_op(k, 3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678, 0);
            do_op(k, 3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678, 0);
            do_op(k, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
            do_op(k, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        end
        do_op(0, 3'd4, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 0);

        // Stall in DONE for 10 cycles
        do_op(1, 3'd2, 32'hFFFF_FFF0, 32'h8000_0001, ref_model(3'd2, 32'hFFFF_FFF0, 32'h8000_0001), 10);

        // Reset in the middle of CALC (counter = 15), with in_valid high during reset
        @(negedge clk);
        in_valid[1] = 1'b1;
        op[1] = 3'd1; op1[1] = 32'hDEAD_BEEF; op2[1] = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("mid_busy", {31'd0, busy[1]}, 32'd1);
        rst_n = 1'b0;
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("midrst_busy", {31'd0, busy[1]}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready[1]}, 32'd1);
        check("midrst_result", result[1], 32'd0);
        in_valid[1] = 1'b0;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid[1] === 1'b1 || busy[1] === 1'b1) saw_valid = 1'b1;
        end
        check("midrst_no_valid", {31'd0, saw_valid}, 32'd0);
        do_op(1, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);

        // Randomized transactions with corner-biased operands
        for (int i = 0; i < 48; i++) begin
            d   = (i % 4 == 0) ? 0 : 1;
            o   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: begin a = 32'h8000_0000; end
                4: begin b = 32'h0000_0001 << $urandom_range(0, 31); end
                default: ;
            endcase
            do_op(d, o, a, b, ref_model(o, a, b), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one parameter: EARLY_OUT, default 1, 1 = divide-by-zero and signed-overflow divides bypass iteration.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 op1  input  32  rs1 value (multiplicand / dividend).
REQ-008 op2  input  32  rs2 value (multiplier / divisor).
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  32  operation result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIXUP, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; acceptance is in_valid && in_ready at a rising edge, and op/op1/op2 SHALL be registered there (inputs are don't-care afterwards).
REQ-015 On acceptance: normal op -> CALC with 5-bit counter = 0; if EARLY_OUT=1 and the op is a divide/remainder with op2 = 0 or signed overflow (op1 = 0x80000000, op2 = 0xFFFFFFFF, op 4/6) -> DONE directly.
REQ-016 CALC SHALL perform one iteration per cycle on operand magnitudes for exactly 32 cycles (counter 0..31), then go to FIXUP.
REQ-017 Multiply SHALL use shift-add on 32-bit magnitudes into a 64-bit unsigned product; signed-ness per op: MUL/MULH both signed, MULHSU op1 signed and op2 unsigned, MULHU both unsigned.
REQ-018 Divide SHALL use restoring division on 32-bit magnitudes: quotient and remainder registers are 32 bits, and the partial remainder is 33 bits.
REQ-019 FIXUP (1 cycle) SHALL negate the results: product if the operand signs differ, quotient if the dividend and divisor signs differ, remainder if the dividend is negative; signed ops only. Then go to DONE.
REQ-020 Result selection SHALL be: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-021 Divide by zero SHALL give: DIV/DIVU = 0xFFFFFFFF, REM/REMU = op1, for both EARLY_OUT settings.
REQ-022 Signed overflow SHALL give: DIV = 0x80000000, REM = 0, for both EARLY_OUT settings.
REQ-023 Latency: normal op, out_valid first high in the cycle after the 34th rising edge following the acceptance edge; early-out, in the cycle after the 1st edge.
REQ-024 DONE: out_valid = 1 and result SHALL be stable until the handshake edge (out_valid && out_ready).
REQ-025 At the handshake edge the FSM SHALL return to IDLE; a new request can be accepted no earlier than the following edge (no back-to-back overlap).
REQ-026 out_ready held low SHALL stall in DONE indefinitely with no change to result.
REQ-027 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.

Reset
REQ-028 rst_n = 0 at a rising edge SHALL force IDLE with in_ready = 1, out_valid = 0, busy = 0, result = 0, counter = 0, and all datapath registers = 0.
REQ-029 Reset mid-operation (CALC, FIXUP or DONE) SHALL abort without producing out_valid; the first acceptance is possible at the first edge with rst_n = 1.
REQ-030 in_valid during reset SHALL NOT be accepted.

Verification
REQ-031 MUL op1 = 7, op2 = 0xFFFFFFFD (-3) -> result 0xFFFFFFEB after 34 edges; MULH same operands -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-033 DIV/DIVU/REM/REMU with op2 = 0, op1 = 0x12345678 -> 0xFFFFFFFF, 0xFFFFFFFF, 0x12345678, 0x12345678; latency 1 edge (EARLY_OUT = 1) or 34 edges (EARLY_OUT = 0).
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-035 out_ready held low 10 cycles in DONE -> out_valid and result held; in_ready stays 0; accepted on the edge out_ready rises, then in_ready = 1.
REQ-036 rst_n pulsed low at CALC counter = 15 -> no out_valid; next request MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
